// File: rtl/gat_ctrl_pkg.sv
// Shared definitions for the GAT layer sequencer: FSM state encoding and
// the bit layout of the status word.
package gat_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        GAT_IDLE      = 3'd0,
        GAT_WAIT_LOAD = 3'd1,
        GAT_ARM       = 3'd2,
        GAT_RUN       = 3'd3,
        GAT_DRAIN     = 3'd4,
        GAT_FINISH    = 3'd5
    } gat_state_e;

    // status word layout
    localparam int unsigned STATUS_STATE_LSB = 0;
    localparam int unsigned STATUS_LAYER_LSB = 3;
    localparam int unsigned STATUS_PERF_LSB  = 16;
    localparam int unsigned STATUS_PERF_W    = 16;

endpackage

// File: rtl/gat_layer_ctrl_if.sv
// Feature output stream (AXI-Stream style, no sideband beyond tlast).
//   master: drives tdata/tvalid/tlast, samples tready
//   slave : samples tdata/tvalid/tlast, drives tready
interface gat_layer_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gat_stream_skid_fifo.sv
// Small circular FIFO absorbing feature BRAM read returns while the stream
// consumer stalls.
//   push/push_data : write side (dropped if full; the caller's credit scheme
//                    keeps that from happening)
//   pop/pop_data   : read side, pop_data is the head word (valid if !empty)
//   empty/count    : occupancy
module gat_stream_skid_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // pointer/count update; pointers wrap at DEPTH (not necessarily a power of 2)
    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/gat_layer_ctrl.sv
// GAT accelerator layer sequencer. Per start: for each layer, wait for the
// host to (re)load the H-data, node-info and weight BRAMs, select the layer,
// wait for the core to finish, then stream the new-feature BRAM out.
// Optional build macro GAT_CTRL_PERF_CNT_EN adds perf_cycles (RUN cycles of
// the current layer, mirrored to status[31:16]).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start                       begin layer 0 (accepted only in IDLE)
//   *_load_done                 host BRAM load levels
//   gat_layer / gat_ready       layer select to core / core completion
//   feat_bram_addrb/_dout       feature BRAM read port (fixed latency)
//   m_feat                      feature output stream (master)
//   busy, done, status          sequencer state reporting
module gat_layer_ctrl
    import gat_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LAYERS         = 2,
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned NEW_FEATURE_DEPTH  = 43328,
    parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int unsigned READ_LATENCY       = 2,
    parameter int unsigned LAYER_W            = $clog2(NUM_LAYERS) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          h_data_bram_load_done,
    input  logic                          h_node_info_bram_load_done,
    input  logic                          wgt_bram_load_done,
    output logic                          gat_layer,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
    input  logic [DATA_WIDTH-1:0]         feat_bram_dout,
    gat_layer_ctrl_if.master              m_feat,
    output logic                          busy,
    output logic                          done,
`ifdef GAT_CTRL_PERF_CNT_EN
    output logic [31:0]                   perf_cycles,
`endif
    output logic [31:0]                   status
);

    localparam logic [STATE_W-1:0] ST_IDLE      = GAT_IDLE;
    localparam logic [STATE_W-1:0] ST_WAIT_LOAD = GAT_WAIT_LOAD;
    localparam logic [STATE_W-1:0] ST_ARM       = GAT_ARM;
    localparam logic [STATE_W-1:0] ST_RUN       = GAT_RUN;
    localparam logic [STATE_W-1:0] ST_DRAIN     = GAT_DRAIN;
    localparam logic [STATE_W-1:0] ST_FINISH    = GAT_FINISH;

    localparam int unsigned FIFO_DEPTH = READ_LATENCY + 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRED_W     = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    localparam logic [LAYER_W-1:0]            LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_ADDR  = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);

    logic [STATE_W-1:0]            state_q, state_d;
    logic [LAYER_W-1:0]            layer_q, layer_d;
    logic                          armed_q, armed_d;
    logic                          seen_low_q, seen_low_d;
    logic [NEW_FEATURE_ADDR_W-1:0] addr_q, addr_d;
    logic                          issue_done_q, issue_done_d;
    logic [NEW_FEATURE_ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [READ_LATENCY-1:0]       vld_sr_q, vld_sr_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          gat_layer_q, gat_layer_d;

    logic                  all_loaded, all_low;
    logic [CRED_W-1:0]     inflight, outstanding;
    logic                  issue, push, pop, last_pop;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign all_loaded = h_data_bram_load_done & h_node_info_bram_load_done & wgt_bram_load_done;
    assign all_low    = ~(h_data_bram_load_done | h_node_info_bram_load_done | wgt_bram_load_done);

    // read credit: buffered words plus reads still in the BRAM pipe may never exceed FIFO depth
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight = inflight + CRED_W'(vld_sr_q[i]);
        end
        outstanding = CRED_W'(fifo_count) + inflight;
        issue       = (state_q == ST_DRAIN) && !issue_done_q && (outstanding < CRED_W'(FIFO_DEPTH));
        push        = vld_sr_q[READ_LATENCY-1];
        pop         = !fifo_empty && m_feat.tready;
        last_pop    = pop && (word_idx_q == LAST_ADDR);
        vld_sr_d    = '0;
        vld_sr_d[0] = issue;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
    end

    // next-state and sequencing flags
    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        armed_d      = armed_q;
        seen_low_d   = seen_low_q;
        addr_d       = addr_q;
        issue_done_d = issue_done_q;
        word_idx_d   = word_idx_q;

        // host must show all loads low once before the next layer may start
        if (all_low) armed_d = 1'b1;
        // a low on gat_ready proves the completion level is fresh for this layer
        if (!gat_ready) seen_low_d = 1'b1;

        if (issue) begin
            if (addr_q == LAST_ADDR) issue_done_d = 1'b1;
            else                     addr_d = addr_q + NEW_FEATURE_ADDR_W'(1);
        end
        if (pop) begin
            word_idx_d = last_pop ? '0 : word_idx_q + NEW_FEATURE_ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_LOAD;
                    armed_d = 1'b1;
                    layer_d = '0;
                end
            end
            ST_WAIT_LOAD: begin
                if (all_loaded && armed_q) state_d = ST_ARM;
            end
            ST_ARM: begin
                state_d      = ST_RUN;
                armed_d      = 1'b0;
                seen_low_d   = 1'b0;
                addr_d       = '0;
                issue_done_d = 1'b0;
                word_idx_d   = '0;
            end
            ST_RUN: begin
                if (seen_low_q && gat_ready) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    if (layer_q == LAST_LAYER) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_WAIT_LOAD;
                        layer_d = layer_q + LAYER_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                layer_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISH);
        gat_layer_d = (layer_d == LAST_LAYER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            layer_q      <= '0;
            armed_q      <= 1'b0;
            seen_low_q   <= 1'b0;
            addr_q       <= '0;
            issue_done_q <= 1'b0;
            word_idx_q   <= '0;
            vld_sr_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            gat_layer_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            armed_q      <= armed_d;
            seen_low_q   <= seen_low_d;
            addr_q       <= addr_d;
            issue_done_q <= issue_done_d;
            word_idx_q   <= word_idx_d;
            vld_sr_q     <= vld_sr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            gat_layer_q  <= gat_layer_d;
        end
    end

    gat_stream_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (feat_bram_dout),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef GAT_CTRL_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // RUN-cycle counter: cleared in ARM, frozen outside RUN, saturating
    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_ARM)                     perf_d = '0;
        else if (state_q == ST_RUN && ~&perf_q)    perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

    always_comb begin
        status = '0;
        status[STATUS_STATE_LSB +: STATE_W] = state_q;
        status[STATUS_LAYER_LSB +: LAYER_W] = layer_q;
`ifdef GAT_CTRL_PERF_CNT_EN
        status[STATUS_PERF_LSB +: STATUS_PERF_W] = perf_q[STATUS_PERF_W-1:0];
`endif
    end

    assign feat_bram_addrb = addr_q;
    assign m_feat.tdata    = fifo_head;
    assign m_feat.tvalid   = !fifo_empty;
    assign m_feat.tlast    = !fifo_empty && (word_idx_q == LAST_ADDR);
    assign busy            = busy_q;
    assign done            = done_q;
    assign gat_layer       = gat_layer_q;

endmodule

// File: tb/tb_gat_layer_ctrl.sv
// Directed bench for gat_layer_ctrl (NUM_LAYERS=2, depth 8, read latency 2).
// Feature BRAM model returns 0x10+addr two cycles after the address.
module tb_gat_layer_ctrl;

    localparam int unsigned NL    = 2;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned RL    = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          h_done, n_done, w_done;
    logic          gat_layer;
    logic          gat_ready;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dout;
    logic [DW-1:0] bram_p1;
    logic          busy, done;
    logic [31:0]   status;
`ifdef GAT_CTRL_PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    int total = 0;
    int bad = 0;
    int mon_idx = 0;
    int words_total = 0;
    int max_cnt = 0;
    int max_out = 0;

    gat_layer_ctrl_if #(.DATA_WIDTH(DW)) feat_if ();

    gat_layer_ctrl #(
        .NUM_LAYERS        (NL),
        .DATA_WIDTH        (DW),
        .NEW_FEATURE_DEPTH (DEPTH),
        .READ_LATENCY      (RL)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .start                      (start),
        .h_data_bram_load_done      (h_done),
        .h_node_info_bram_load_done (n_done),
        .wgt_bram_load_done         (w_done),
        .gat_layer                  (gat_layer),
        .gat_ready                  (gat_ready),
        .feat_bram_addrb            (addrb),
        .feat_bram_dout             (dout),
        .m_feat                     (feat_if),
        .busy                       (busy),
        .done                       (done),
`ifdef GAT_CTRL_PERF_CNT_EN
        .perf_cycles                (perf_cycles),
`endif
        .status                     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // two-cycle BRAM read pipe
    always_ff @(posedge clk) begin
        bram_p1 <= 8'h10 + 8'(addrb);
        dout    <= bram_p1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic v);
        h_done = v;
        n_done = v;
        w_done = v;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (status[2:0] !== st && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(status[2:0]), 32'(st));
    endtask

    // stream scoreboard: every handshake must carry the next word in address order
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_idx = 0;
        end else begin
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
            if (int'(dut.outstanding) > max_out) max_out = int'(dut.outstanding);
            if (feat_if.tvalid && feat_if.tready) begin
                check("stream_data", 32'(feat_if.tdata), 32'((16 + mon_idx) & 255));
                check("stream_tlast", 32'(feat_if.tlast), (mon_idx == 7) ? 32'd1 : 32'd0);
                words_total++;
                mon_idx = (mon_idx == 7) ? 0 : mon_idx + 1;
            end
        end
    end

    initial begin
        int  n;
        logic got_done;

        rst_n         = 1'b0;
        start         = 1'b0;
        set_flags(1'b0);
        gat_ready     = 1'b0;
        feat_if.tready = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_status", status, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_tvalid", 32'(feat_if.tvalid), 32'h0);
        check("rst_tlast", 32'(feat_if.tlast), 32'h0);
        check("rst_gat_layer", 32'(gat_layer), 32'h0);
        check("rst_addrb", 32'(addrb), 32'h0);

        tick();
        rst_n = 1'b1;

        // layer 0
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_wait_load", 32'(status[15:0]), 32'h1);
        check("start_busy", 32'(busy), 32'h1);
        set_flags(1'b1);
        wait_state("l0_arm", 3'd2, 10);
        wait_state("l0_run", 3'd3, 3);
        check("l0_gat_layer", 32'(gat_layer), 32'h0);
        repeat (19) tick();
        gat_ready = 1'b1;
        wait_state("l0_drain", 3'd4, 5);
`ifdef GAT_CTRL_PERF_CNT_EN
        check("perf_at_drain", perf_cycles, 32'd20);
        check("perf_status_mirror", 32'(status[31:16]), 32'd20);
        repeat (4) tick();
        @(negedge clk);
        check("perf_held", perf_cycles, 32'd20);
`endif
        wait_state("l0_back_wait_load", 3'd1, 100);
        check("l0_status", 32'(status[15:0]), 32'h9);
        check("l0_words", 32'(words_total), 32'd8);
        check("l0_gat_layer_next", 32'(gat_layer), 32'h1);

        // flags still high: no re-arm
        repeat (10) tick();
        @(negedge clk);
        check("no_rearm_hold", 32'(status[15:0]), 32'h9);

        // reload pulse, then layer 1 with a stale gat_ready
        tick();
        set_flags(1'b0);
        tick();
        set_flags(1'b1);
        wait_state("l1_arm", 3'd2, 5);
        check("l1_gat_layer", 32'(gat_layer), 32'h1);
        check("l1_arm_status", 32'(status[15:0]), 32'hA);
        feat_if.tready = 1'b0;
        wait_state("l1_run", 3'd3, 3);
        repeat (5) tick();
        @(negedge clk);
        check("stale_ready_hold", 32'(status[2:0]), 32'd3);
        tick();
        gat_ready = 1'b0;
        tick();
        gat_ready = 1'b1;
        wait_state("l1_drain", 3'd4, 5);

        // long backpressure: issue stalls at three words
        repeat (50) tick();
        @(negedge clk);
        check("stall_fifo_count", 32'(dut.fifo_count), 32'd3);
        check("stall_addrb", 32'(addrb), 32'd3);
        check("stall_tvalid", 32'(feat_if.tvalid), 32'h1);
        check("stall_head", 32'(feat_if.tdata), 32'h10);

        // random ~30% backpressure until done; start alongside done is ignored
        got_done = 1'b0;
        n = 0;
        while (!got_done && n < 400) begin
            tick();
            feat_if.tready = ($urandom_range(0, 9) >= 3);
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                start = 1'b1;
            end
            n++;
        end
        check("l1_done_seen", 32'(got_done), 32'h1);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_status", 32'(status[15:0]), 32'h0);
        check("idle_gat_layer", 32'(gat_layer), 32'h0);
        check("l1_words", 32'(words_total), 32'd16);
        check("max_fifo_count", 32'(max_cnt), 32'd3);
        check("max_outstanding", 32'(max_out), 32'd3);

        // reset in the middle of a drain
        gat_ready      = 1'b0;
        feat_if.tready = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state("r_run", 3'd3, 10);
        tick();
        gat_ready = 1'b1;
        wait_state("r_drain", 3'd4, 5);
        n = 0;
        while (mon_idx < 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("r_three_words", 32'(mon_idx), 32'd3);
        rst_n = 1'b0;
        #1;
        check("r_tvalid", 32'(feat_if.tvalid), 32'h0);
        check("r_busy", 32'(busy), 32'h0);
        check("r_status", status, 32'h0);
        check("r_addrb", 32'(addrb), 32'h0);
        tick();
        tick();
        rst_n     = 1'b1;
        gat_ready = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state("r2_run", 3'd3, 10);
        tick();
        gat_ready = 1'b1;
        wait_state("r2_drain", 3'd4, 5);
        wait_state("r2_wait_load", 3'd1, 100);
        check("r2_status", 32'(status[15:0]), 32'h9);
        check("r2_words", 32'(words_total), 32'd27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gat_layer_ctrl.md
Name: gat_layer_ctrl

Overview:
Top-level sequencer for the GAT accelerator core. It waits for the host to load the H-data, node-info and weight BRAMs, then selects the layer and waits for the core to finish. It drains the new-feature BRAM read port into an AXI-Stream-style output with backpressure, and repeats this for each layer. It sits between the register bank / DMA and the accelerator core.

Parameters:
NUM_LAYERS, 2, number of GAT layers sequenced per start
DATA_WIDTH, 8, feature word width
NEW_FEATURE_DEPTH, 43328, feature words per layer (NUM_SUBGRAPHS*NUM_FEATURE_OUT)
NEW_FEATURE_ADDR_W, $clog2(NEW_FEATURE_DEPTH), feature BRAM word address width
READ_LATENCY, 2, fixed feature BRAM read latency in cycles (>=1)
LAYER_W, $clog2(NUM_LAYERS)+1, layer index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins layer 0; ignored unless IDLE
h_data_bram_load_done  in  1  level, H-data BRAM loaded
h_node_info_bram_load_done  in  1  level, node-info BRAM loaded
wgt_bram_load_done  in  1  level, weight BRAM loaded
gat_layer  out  1  layer select to core (0 = layer 0, 1 = final layer)
gat_ready  in  1  core completion level
feat_bram_addrb  out  NEW_FEATURE_ADDR_W  feature BRAM read word address
feat_bram_dout  in  DATA_WIDTH  feature BRAM read data
m_feat_tdata  out  DATA_WIDTH  streamed feature word
m_feat_tvalid  out  1  stream valid
m_feat_tready  in  1  stream ready
m_feat_tlast  out  1  last word of current layer
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after final layer drained
status  out  32  [2:0] state, [3+:LAYER_W] layer, rest 0

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0; layer=0; internal FIFO empty.
- FSM:
  - IDLE: on start, go to WAIT_LOAD.
  - WAIT_LOAD: when all three load_done flags are high and armed=1, go to ARM.
  - ARM: one cycle; drive gat_layer; go to RUN.
  - RUN: once seen_low=1 and gat_ready=1, go to DRAIN.
  - DRAIN: after the last word handshakes, if layer==NUM_LAYERS-1 go to FINISH; else layer++ and go to WAIT_LOAD.
  - FINISH: pulse done for one cycle; go to IDLE.
- armed: set to 1 on entry from IDLE. Cleared on entering RUN. Set again once all load_done flags have been observed low together at least one cycle, so the host must reload before each later layer.
- seen_low: cleared on entering RUN; set when gat_ready=0. This rejects a stale gat_ready left over from the previous layer.
- gat_layer = (layer==NUM_LAYERS-1). It is held stable from ARM through DRAIN.
- DRAIN read engine:
  - Issue counter addr counts 0..NEW_FEATURE_DEPTH-1; feat_bram_addrb = addr.
  - A read issues only when (fifo_count + inflight) < READ_LATENCY+1. inflight is tracked by a READ_LATENCY-deep valid shift register.
  - Returned data is pushed into a skid FIFO of depth READ_LATENCY+1.
  - m_feat_tvalid = FIFO not empty. A pop happens when tvalid and tready are both high.
  - tlast is asserted with word index NEW_FEATURE_DEPTH-1 of each layer.
  - Word order equals address order. No drops or duplicates under any tready pattern.
- m_feat_tready may be held low indefinitely: issue stalls, and no FIFO overflow is permitted.
- start in any non-IDLE state is ignored. done and start in the same cycle: done completes and start is ignored.
- Async reset mid-DRAIN: FIFO and inflight flushed, tvalid=0 immediately, layer reset to 0.
- Address width must cover NEW_FEATURE_DEPTH-1. The issue counter never wraps past the last address.

Optional Feature:
GAT_CTRL_PERF_CNT_EN: adds output perf_cycles[31:0], counting clk cycles spent in RUN for the current layer. It clears on ARM, freezes on DRAIN entry and saturates at 0xFFFFFFFF. It is mirrored to status[31:16] as the low 16 bits. Without the macro the port is absent and status[31:16]=0.

Decomposition:
- Package gat_ctrl_pkg:
  - state enum (IDLE=0, WAIT_LOAD=1, ARM=2, RUN=3, DRAIN=4, FINISH=5)
  - status bit-offset constants
- One sub-module gat_stream_skid_fifo holds the parameterised depth/width FIFO with count output.
- The read-issue credit logic stays in gat_layer_ctrl.

Test Plan:
- Params NUM_LAYERS=2, NEW_FEATURE_DEPTH=8, READ_LATENCY=2; BRAM model returns 0x10+addr. Stimulus: start; load flags set; gat_ready 0 for 20 cycles then 1; tready=1. Response: gat_layer=0; 8 words 0x10..0x17, tlast on 0x17; returns to WAIT_LOAD.
- Layer 1 re-arm: load flags held high after layer 0 -> FSM stays in WAIT_LOAD; flags drop 1 cycle then rise -> ARM, gat_layer=1, drain completes, done pulses 1 cycle, busy falls.
- Stale ready: gat_ready held 1 at RUN entry for 5 cycles then 0 then 1 -> DRAIN entered only after the low phase.
- Backpressure: tready random 30% plus a 50-cycle low burst -> exact ordered sequence, FIFO count never exceeds 3, at most 3 reads outstanding.
- Reset mid-DRAIN after 3 words: rst_n low -> tvalid=0, busy=0, status=0 the same cycle. A new start after reset replays layer 0 from address 0.
- GAT_CTRL_PERF_CNT_EN: RUN lasting 20 cycles -> perf_cycles=20, held through DRAIN.
